bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, processing one input bit per clock.
It is the clocked, area-lean successor to the combinational converter feeding the seven-segment display path.
Input width, output digit count and signed mode are parametrised, with a start/busy/done handshake and an overflow flag.
Outputs hold the last result between conversions.

Parameters:
IN_WIDTH, 32, width of binary input (>= 4)
DIGITS, 10, number of BCD digits produced (>= 1)
SIGNED, 0, 1 = treat input as two's complement; convert magnitude and report sign

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only in IDLE
binary  input  IN_WIDTH  value to convert; sampled on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse: bcd/negative/overflow just updated
bcd  output  4*DIGITS  result; digit k at bits [4k+3:4k], digit 0 = ones
negative  output  1  SIGNED=1 and input MSB was 1; always 0 when SIGNED=0
overflow  output  1  value needs more than DIGITS digits; bcd holds value mod 10^DIGITS

Behaviour:
- Reset, sampled on any edge, in any state, including mid-conversion: state=IDLE; busy=0, done=0, bcd=0, negative=0, overflow=0; working registers cleared; the partial conversion is discarded.
- States: IDLE, SHIFT.
- IDLE + start=1 at edge N:
  - Capture the magnitude into the shift register: binary, or its two's-complement negation when SIGNED=1 and binary[IN_WIDTH-1]=1. The negation of -2^(IN_WIDTH-1) is 2^(IN_WIDTH-1) as unsigned IN_WIDTH bits.
  - Latch the sign, clear the digit accumulator and sticky overflow, load bit counter = IN_WIDTH, go to SHIFT, busy=1.
- SHIFT, each edge N+1..N+IN_WIDTH:
  - Every accumulator digit >= 5 gets +3, all digits in the same cycle.
  - The {digits, shift register} chain then shifts left one bit; the shift-register MSB enters digit 0 bit 0.
  - A 1 shifted out of the top digit's bit 3 sets sticky overflow.
  - Decrement the counter.
- On edge N+IN_WIDTH (counter reaches 0):
  - Write bcd, negative and overflow from the working registers.
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done high in the cycle following edge N+IN_WIDTH. busy is high for exactly IN_WIDTH cycles.
- Throughput: start accepted in the cycle done is high, giving back-to-back conversions every IN_WIDTH+1 cycles.
- start while busy=1 is ignored, not queued. binary changes during SHIFT have no effect.
- bcd, negative and overflow change only on the done edge or on reset.
- Digits in bcd are always 0..9.
- Zero input with SIGNED=1 gives negative=0.

Test Plan:
- IN_WIDTH=32, DIGITS=10, SIGNED=0: binary=0, start pulse -> done exactly 33 cycles after the start edge, bcd=0, overflow=0, busy high for 32 cycles.
- Same config: binary=32'hFFFFFFFF -> bcd digits 4,2,9,4,9,6,7,2,9,5 (MSD..LSD), overflow=0. Then binary=32'd1234567890 back-to-back (start in the done cycle) -> 1234567890, done 33 cycles later.
- IN_WIDTH=16, DIGITS=4: binary=12345 -> bcd=16'h2345, overflow=1. Then binary=9999 -> bcd=16'h9999, overflow=0.
- IN_WIDTH=8, DIGITS=3, SIGNED=1: binary=8'hFB -> bcd=12'h005, negative=1. binary=8'h80 -> bcd=12'h128, negative=1. binary=8'h7F -> 12'h127, negative=0.
- start re-asserted and binary changed during SHIFT -> ignored, original result delivered, a single done pulse.
- reset asserted at shift cycle 10 of 32 -> next cycle busy=0, bcd=0, no done. A new start then converts 42 -> bcd=...0042 normally.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus of the sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 10
);
  logic                  start;
  logic [IN_WIDTH-1:0]   binary;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negative;
  logic                  overflow;

  modport master (
    output start, binary,
    input  busy, done, bcd, negative, overflow
  );

  modport slave (
    input  start, binary,
    output busy, done, bcd, negative, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// optional two's-complement input, sticky overflow when DIGITS is too small.
module bin2bcd_seq #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 10,
  parameter int SIGNED   = 0
) (
  input logic          clock,
  input logic          reset,
  bin2bcd_seq_if.slave bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IN_WIDTH-1:0] r_sr;
  logic [IN_WIDTH-1:0] w_mag;
  logic [IN_WIDTH-1:0] w_sr_shl;
  logic [BW-1:0]       r_acc;
  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_acc_shl;
  logic [CW-1:0]       r_cnt;
  logic                r_neg;
  logic                r_ovf;
  logic                w_in_neg;
  logic                w_shout;
  logic                w_last;
  logic                r_done;
  logic [BW-1:0]       r_bcd;
  logic                r_bcd_neg;
  logic                r_bcd_ovf;

  // Negating -2^(IN_WIDTH-1) wraps back to the same bit pattern, which read
  // as unsigned is exactly the required magnitude.
  always_comb begin
    w_in_neg = (SIGNED != 0) && bus.binary[IN_WIDTH-1];
    w_mag    = w_in_neg ? (~bus.binary + IN_WIDTH'(1)) : bus.binary;
  end

  always_comb begin
    w_adj = r_acc;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    w_acc_shl = {w_adj[BW-2:0], r_sr[IN_WIDTH-1]};
    w_sr_shl  = {r_sr[IN_WIDTH-2:0], 1'b0};
    w_shout   = w_adj[BW-1];
    w_last    = (r_state == SHIFT) && (r_cnt == CW'(1));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sr      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_bcd_neg <= 1'b0;
      r_bcd_ovf <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sr  <= w_mag;
            r_neg <= w_in_neg;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= CW'(IN_WIDTH);
          end
        end
        SHIFT: begin
          r_sr  <= w_sr_shl;
          r_acc <= w_acc_shl;
          r_ovf <= r_ovf | w_shout;
          r_cnt <= r_cnt - CW'(1);
          // The final shift result goes straight to the outputs on the same edge.
          if (w_last) begin
            r_bcd     <= w_acc_shl;
            r_bcd_neg <= r_neg;
            r_bcd_ovf <= r_ovf | w_shout;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state == SHIFT);
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.negative = r_bcd_neg;
  assign bus.overflow = r_bcd_ovf;

endmodule
